// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode parametrised VGA raster timing generator.
// Holds two complete timing sets, switches mode only at the frame wrap,
// and registers every output from the next counter state so sync, blanking,
// coordinates and strobes all describe the presented h_count/v_count.

module vga_timing_gen #(
    parameter int CW      = 11,
    parameter int H0_SW   = 136,
    parameter int H0_BP   = 160,
    parameter int H0_ACT  = 1024,
    parameter int H0_FP   = 24,
    parameter int V0_SW   = 6,
    parameter int V0_BP   = 29,
    parameter int V0_ACT  = 768,
    parameter int V0_FP   = 3,
    parameter int H1_SW   = 96,
    parameter int H1_BP   = 48,
    parameter int H1_ACT  = 640,
    parameter int H1_FP   = 16,
    parameter int V1_SW   = 2,
    parameter int V1_BP   = 33,
    parameter int V1_ACT  = 480,
    parameter int V1_FP   = 10,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic          clk_65M,
    input  logic          clear,
    input  logic          en,
    input  logic          mode_sel,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          vid_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          mode_act
);

    // Segment boundaries per mode, all as CW-bit positions.
    localparam logic [CW-1:0] H0_LAST    = CW'(H0_SW + H0_BP + H0_ACT + H0_FP - 1);
    localparam logic [CW-1:0] V0_LAST    = CW'(V0_SW + V0_BP + V0_ACT + V0_FP - 1);
    localparam logic [CW-1:0] H1_LAST    = CW'(H1_SW + H1_BP + H1_ACT + H1_FP - 1);
    localparam logic [CW-1:0] V1_LAST    = CW'(V1_SW + V1_BP + V1_ACT + V1_FP - 1);

    localparam logic [CW-1:0] H0_SYNC_END = CW'(H0_SW);
    localparam logic [CW-1:0] H0_ACT_BEG  = CW'(H0_SW + H0_BP);
    localparam logic [CW-1:0] H0_ACT_END  = CW'(H0_SW + H0_BP + H0_ACT);
    localparam logic [CW-1:0] V0_SYNC_END = CW'(V0_SW);
    localparam logic [CW-1:0] V0_ACT_BEG  = CW'(V0_SW + V0_BP);
    localparam logic [CW-1:0] V0_ACT_END  = CW'(V0_SW + V0_BP + V0_ACT);

    localparam logic [CW-1:0] H1_SYNC_END = CW'(H1_SW);
    localparam logic [CW-1:0] H1_ACT_BEG  = CW'(H1_SW + H1_BP);
    localparam logic [CW-1:0] H1_ACT_END  = CW'(H1_SW + H1_BP + H1_ACT);
    localparam logic [CW-1:0] V1_SYNC_END = CW'(V1_SW);
    localparam logic [CW-1:0] V1_ACT_BEG  = CW'(V1_SW + V1_BP);
    localparam logic [CW-1:0] V1_ACT_END  = CW'(V1_SW + V1_BP + V1_ACT);

    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] h_last;
    logic [CW-1:0] v_last;
    logic          at_line_end;
    logic          at_frame_end;

    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          mode_nxt;
    logic          line_start_nxt;
    logic          frame_start_nxt;

    logic [CW-1:0] hs_end_n;
    logic [CW-1:0] ha_beg_n;
    logic [CW-1:0] ha_end_n;
    logic [CW-1:0] vs_end_n;
    logic [CW-1:0] va_beg_n;
    logic [CW-1:0] va_end_n;

    logic          h_in_act;
    logic          v_in_act;
    logic          h_sync_nxt;
    logic          v_sync_nxt;
    logic          vid_on_nxt;
    logic [CW-1:0] pix_x_nxt;
    logic [CW-1:0] pix_y_nxt;

    // Wrap points of the mode currently driving the raster.
    always_comb begin
        h_last = mode_act ? H1_LAST : H0_LAST;
        v_last = mode_act ? V1_LAST : V0_LAST;
        at_line_end  = (h_count == h_last);
        at_frame_end = at_line_end && (v_count == v_last);
    end

    // Next counter/mode state; en=0 holds everything and suppresses strobes.
    always_comb begin
        h_nxt           = h_count;
        v_nxt           = v_count;
        mode_nxt        = mode_act;
        line_start_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        if (en) begin
            if (at_line_end) begin
                h_nxt          = ZERO;
                line_start_nxt = 1'b1;
                if (at_frame_end) begin
                    v_nxt           = ZERO;
                    mode_nxt        = mode_sel;
                    frame_start_nxt = 1'b1;
                end else begin
                    v_nxt = v_count + ONE;
                end
            end else begin
                h_nxt = h_count + ONE;
            end
        end
    end

    // Segment boundaries of the mode that will own the next position; this
    // is what lets the first pixel of a new frame already use the new mode.
    always_comb begin
        hs_end_n = mode_nxt ? H1_SYNC_END : H0_SYNC_END;
        ha_beg_n = mode_nxt ? H1_ACT_BEG  : H0_ACT_BEG;
        ha_end_n = mode_nxt ? H1_ACT_END  : H0_ACT_END;
        vs_end_n = mode_nxt ? V1_SYNC_END : V0_SYNC_END;
        va_beg_n = mode_nxt ? V1_ACT_BEG  : V0_ACT_BEG;
        va_end_n = mode_nxt ? V1_ACT_END  : V0_ACT_END;
    end

    // Decode the next position into sync, blanking and active coordinates.
    always_comb begin
        h_in_act   = (h_nxt >= ha_beg_n) && (h_nxt < ha_end_n);
        v_in_act   = (v_nxt >= va_beg_n) && (v_nxt < va_end_n);
        vid_on_nxt = h_in_act && v_in_act;
        h_sync_nxt = (h_nxt < hs_end_n) ? HS_POL : ~HS_POL;
        v_sync_nxt = (v_nxt < vs_end_n) ? VS_POL : ~VS_POL;
        pix_x_nxt  = vid_on_nxt ? (h_nxt - ha_beg_n) : ZERO;
        pix_y_nxt  = vid_on_nxt ? (v_nxt - va_beg_n) : ZERO;
    end

    // Register state and every output together so they stay aligned.
    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            h_count     <= ZERO;
            v_count     <= ZERO;
            mode_act    <= 1'b0;
            h_sync      <= HS_POL;
            v_sync      <= VS_POL;
            vid_on      <= 1'b0;
            pix_x       <= ZERO;
            pix_y       <= ZERO;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            mode_act    <= mode_nxt;
            h_sync      <= h_sync_nxt;
            v_sync      <= v_sync_nxt;
            vid_on      <= vid_on_nxt;
            pix_x       <= pix_x_nxt;
            pix_y       <= pix_y_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using small raster parameters so that
// several full frames in both modes fit in a short run. A second instance
// with inverted sync polarity shares the stimulus.

module tb_vga_timing_gen;

    localparam int CW = 8;

    // mode 0: H 4/3/8/2 (HT=17), V 2/2/5/1 (VT=10)
    // mode 1: H 3/2/6/1 (HT=12), V 1/2/4/2 (VT=9)
    int hsw [2] = '{4, 3};
    int hbp [2] = '{3, 2};
    int hact[2] = '{8, 6};
    int hfp [2] = '{2, 1};
    int vsw [2] = '{2, 1};
    int vbp [2] = '{2, 2};
    int vact[2] = '{5, 4};
    int vfp [2] = '{1, 2};

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          vid;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          ls;
        logic          fs;
        logic          mode;
    } exp_t;

    logic          clk_65M;
    logic          clear;
    logic          en;
    logic          mode_sel;

    logic [CW-1:0] a_h, a_v, a_px, a_py;
    logic          a_hs, a_vs, a_vid, a_ls, a_fs, a_mode;
    logic [CW-1:0] b_h, b_v, b_px, b_py;
    logic          b_hs, b_vs, b_vid, b_ls, b_fs, b_mode;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    int mh = 0;
    int mv = 0;
    int mm = 0;
    bit mls = 0;
    bit mfs = 0;

    vga_timing_gen #(
        .CW(CW),
        .H0_SW(4), .H0_BP(3), .H0_ACT(8), .H0_FP(2),
        .V0_SW(2), .V0_BP(2), .V0_ACT(5), .V0_FP(1),
        .H1_SW(3), .H1_BP(2), .H1_ACT(6), .H1_FP(1),
        .V1_SW(1), .V1_BP(2), .V1_ACT(4), .V1_FP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk_65M(clk_65M), .clear(clear), .en(en), .mode_sel(mode_sel),
        .h_count(a_h), .v_count(a_v), .h_sync(a_hs), .v_sync(a_vs),
        .vid_on(a_vid), .pix_x(a_px), .pix_y(a_py),
        .line_start(a_ls), .frame_start(a_fs), .mode_act(a_mode)
    );

    vga_timing_gen #(
        .CW(CW),
        .H0_SW(4), .H0_BP(3), .H0_ACT(8), .H0_FP(2),
        .V0_SW(2), .V0_BP(2), .V0_ACT(5), .V0_FP(1),
        .H1_SW(3), .H1_BP(2), .H1_ACT(6), .H1_FP(1),
        .V1_SW(1), .V1_BP(2), .V1_ACT(4), .V1_FP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk_65M(clk_65M), .clear(clear), .en(en), .mode_sel(mode_sel),
        .h_count(b_h), .v_count(b_v), .h_sync(b_hs), .v_sync(b_vs),
        .vid_on(b_vid), .pix_x(b_px), .pix_y(b_py),
        .line_start(b_ls), .frame_start(b_fs), .mode_act(b_mode)
    );

    initial begin
        clk_65M = 1'b0;
        forever #5 clk_65M = ~clk_65M;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    // Expected outputs for a position, active-low sync polarity.
    function automatic exp_t model_out(int h, int v, int m, bit ls, bit fs);
        exp_t e;
        bit   hin, vin;
        hin   = (h >= hsw[m] + hbp[m]) && (h < hsw[m] + hbp[m] + hact[m]);
        vin   = (v >= vsw[m] + vbp[m]) && (v < vsw[m] + vbp[m] + vact[m]);
        e.h   = CW'(h);
        e.v   = CW'(v);
        e.hs  = (h < hsw[m]) ? 1'b0 : 1'b1;
        e.vs  = (v < vsw[m]) ? 1'b0 : 1'b1;
        e.vid = hin && vin;
        e.px  = e.vid ? CW'(h - hsw[m] - hbp[m]) : '0;
        e.py  = e.vid ? CW'(v - vsw[m] - vbp[m]) : '0;
        e.ls  = ls;
        e.fs  = fs;
        e.mode = m[0];
        return e;
    endfunction

    task automatic check_val(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, push its prediction.
    task automatic do_cycle(input bit e, input bit sel);
        int ht, vt;
        en       = e;
        mode_sel = sel;
        ht  = hsw[mm] + hbp[mm] + hact[mm] + hfp[mm];
        vt  = vsw[mm] + vbp[mm] + vact[mm] + vfp[mm];
        mls = 1'b0;
        mfs = 1'b0;
        if (e) begin
            if (mh == ht - 1) begin
                mh  = 0;
                mls = 1'b1;
                if (mv == vt - 1) begin
                    mv  = 0;
                    mfs = 1'b1;
                    mm  = int'(sel);
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        @(posedge clk_65M);
        #1;
        sb_q.push_back(model_out(mh, mv, mm, mls, mfs));
    endtask

    // Asynchronous clear in the middle of a clock period.
    task automatic do_clear();
        @(negedge clk_65M);
        #2;
        clear = 1'b1;
        #1;
        mh = 0; mv = 0; mm = 0; mls = 0; mfs = 0;
        sb_q.push_back(model_out(0, 0, 0, 1'b0, 1'b0));
        @(posedge clk_65M);
        #1;
        clear = 1'b0;
    endtask

    task automatic run_until_frame(input bit sel, output int n);
        n = 0;
        do begin
            do_cycle(1'b1, sel);
            n++;
        end while (!a_fs && n < 1000);
        if (n >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_wait: no frame_start within %0d cycles", n);
        end
    endtask

    // Monitor: compare both instances against the queued prediction.
    always @(negedge clk_65M) begin
        exp_t e, eb, got_a, got_b;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            eb = e;
            eb.hs = ~e.hs;
            eb.vs = ~e.vs;
            got_a = '{a_h, a_v, a_hs, a_vs, a_vid, a_px, a_py, a_ls, a_fs, a_mode};
            got_b = '{b_h, b_v, b_hs, b_vs, b_vid, b_px, b_py, b_ls, b_fs, b_mode};
            n_checks++;
            if (got_a !== e) begin
                n_fail++;
                $display("FAIL raster_a @%0t: got h=%0d v=%0d hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b m=%b expected h=%0d v=%0d hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b m=%b",
                         $time, got_a.h, got_a.v, got_a.hs, got_a.vs, got_a.vid, got_a.px, got_a.py, got_a.ls, got_a.fs, got_a.mode,
                         e.h, e.v, e.hs, e.vs, e.vid, e.px, e.py, e.ls, e.fs, e.mode);
            end
            n_checks++;
            if (got_b !== eb) begin
                n_fail++;
                $display("FAIL raster_pol @%0t: got h=%0d v=%0d hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b m=%b expected h=%0d v=%0d hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b m=%b",
                         $time, got_b.h, got_b.v, got_b.hs, got_b.vs, got_b.vid, got_b.px, got_b.py, got_b.ls, got_b.fs, got_b.mode,
                         eb.h, eb.v, eb.hs, eb.vs, eb.vid, eb.px, eb.py, eb.ls, eb.fs, eb.mode);
            end
        end
    end

    initial begin
        int n;
        int guard;
        clear    = 1'b1;
        en       = 1'b0;
        mode_sel = 1'b0;
        #1;
        sb_q.push_back(model_out(0, 0, 0, 1'b0, 1'b0));
        @(posedge clk_65M);
        #1;
        clear = 1'b0;

        // Mid-line clear, then restart from (0,0).
        repeat (10) do_cycle(1'b1, 1'b0);
        do_clear();
        repeat (7) do_cycle(1'b1, 1'b0);
        check_val("restart_h", int'(a_h), 7);
        check_val("restart_ls", int'(a_ls), 0);

        // Hold en low for 7 cycles just before the active area starts.
        repeat (7) do_cycle(1'b0, 1'b0);
        check_val("gated_h", int'(a_h), 7);
        repeat (3) do_cycle(1'b1, 1'b0);
        check_val("resume_h", int'(a_h), 10);

        // Mode 0 frame length: 17 x 10.
        run_until_frame(1'b0, n);
        run_until_frame(1'b0, n);
        check_val("frame_len_m0", n, 170);

        // Irregular enable across more than a frame.
        repeat (400) do_cycle(($urandom_range(0, 3) != 0), 1'b0);

        // Request mode 1 mid-frame; applies at the wrap only.
        guard = 0;
        while (mv != 5 && guard < 500) begin
            do_cycle(1'b1, 1'b0);
            guard++;
        end
        run_until_frame(1'b1, n);
        check_val("mode_after_switch", int'(a_mode), 1);
        run_until_frame(1'b1, n);
        check_val("frame_len_m1", n, 108);

        // mode_sel wiggling away from the frame wrap has no effect.
        repeat (50) do_cycle(1'b1, 1'($urandom_range(0, 1)));
        check_val("mode_hold", int'(a_mode), 1);
        run_until_frame(1'b0, n);
        check_val("mode_back", int'(a_mode), 0);

        // Switch to mode 1 again, then clear mid-frame: back to mode 0.
        run_until_frame(1'b1, n);
        repeat (40) do_cycle(1'b1, 1'b1);
        do_clear();
        check_val("clear_mode", int'(a_mode), 0);
        repeat (200) do_cycle(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));

        @(negedge clk_65M);
        @(negedge clk_65M);
        check_val("queue_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
